ascon_size_encoder: RTL and testbench
=====================================

Name: ascon_size_encoder

Overview:
- Inverse of the AEAD128 size decoder. It counts 128-bit blocks accepted on the block stream and rebuilds the associated-data (AD) and data (DI) byte sizes.
- Reconstruction rule: size = {full_block_count, last_block_bytes}.
- Placement: on the output side of the input formatter/padder, feeding the tag/length report and the register interface.
- Phase order is fixed: AD first, then DI. Each phase is terminated by exactly one last (padding) block carrying 0..15 bytes.

Parameters:
- SIZE_WIDTH, 32, width of the byte-size outputs.
- BLOCK_AW, 28, full-block counter width; must equal SIZE_WIDTH-PAD_AW.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  pulse; clears counters and enters the AD phase from any state.
- blk_valid_i  in  1  a block is presented.
- blk_ready_o  out  1  the encoder accepts the presented block.
- blk_last_i  in  1  presented block is the last (padding) block of the current phase.
- blk_bytes_i  in  PAD_AW  valid data bytes in the last block (0..15); ignored when blk_last_i=0.
- ad_size_o  out  SIZE_WIDTH  reconstructed AD byte count.
- di_size_o  out  SIZE_WIDTH  reconstructed DI byte count.
- busy_o  out  1  encoder is in the AD or DI phase.
- done_o  out  1  both sizes are final.
- overflow_o  out  1  sticky flag: block counter saturated.

Behaviour:
- Reset: state IDLE; all outputs 0 (ad_size_o, di_size_o, blk_ready_o, busy_o, done_o, overflow_o).
- A transfer occurs on blk_valid_i && blk_ready_o.
- blk_ready_o = (state==AD || state==DI) && !start_i. It is combinational from the state register and start_i.
- FSM states: IDLE, AD, DI, DONE.
  - start_i=1 in any state: next state AD; counters, pad registers and overflow_o cleared. start_i has priority over any transfer in the same cycle.
  - AD, non-last transfer: ad_blk_cnt += 1.
  - AD, last transfer: ad_pad <= blk_bytes_i; ad_blk_cnt unchanged; next state DI.
  - DI: same rules applied to di_blk_cnt/di_pad; last transfer moves to DONE.
  - DONE: holds until start_i. IDLE and DONE ignore blk_valid_i.
- Output mapping, all registered, no combinational path from inputs:
  - ad_size_o = {ad_blk_cnt, ad_pad}; di_size_o = {di_blk_cnt, di_pad}.
  - Both outputs are updated the cycle after each accepted transfer.
- busy_o = state in {AD, DI}. done_o = state==DONE (level); it rises the cycle after the DI last transfer.
- Empty phase: a last block with blk_bytes_i=0 as the first transfer gives size 0.
- Reset mid-operation returns to the reset state; a partial count is lost.
- Counter increments use BLOCK_AW-bit arithmetic; increment behaviour at all-ones is set by the optional feature below.

Optional Feature:
- Macro: ASCON_SIZE_ENC_OVF_EN.
- Defined:
  - Each block counter saturates at 2^BLOCK_AW-1.
  - A non-last transfer while the counter is at all-ones sets overflow_o. overflow_o is cleared only by start_i or rst_i.
- Undefined:
  - Counters wrap modulo 2^BLOCK_AW.
  - overflow_o is tied to 0.

Decomposition:
- Shared package ascon_pack:
  - existing PAD_AW (=4, 16-byte block);
  - new enum ascon_size_enc_state_e {IDLE, AD, DI, DONE};
  - new constant BLK_BYTES=16.
- Sub-module ascon_blk_counter: BLOCK_AW-bit counter with clear, increment, optional saturation and overflow flag. Instantiated twice (AD and DI).

Test Plan:
- Nominal sizes: start; AD: 2 non-last blocks, then last with bytes=5; DI: 1 non-last, then last with bytes=0 -> ad_size_o=37, di_size_o=16, done_o=1 the cycle after the DI last transfer.
- Both phases empty: start; AD last bytes=0; DI last bytes=0 -> both sizes 0, done_o=1 two transfers after start.
- Ready gating and start priority:
  - blk_valid_i=1 held in IDLE and in DONE -> blk_ready_o=0, sizes unchanged.
  - start_i with blk_valid_i=1 in AD -> no count, blk_ready_o=0 that cycle.
- Restart mid-DI: AD sizes 37, DI in progress, then start_i -> next cycle state AD, ad_size_o=di_size_o=0, done_o=0.
- Overflow (SIZE_WIDTH=8, BLOCK_AW=4): 16 non-last AD blocks.
  - With macro: ad_blk_cnt=15, overflow_o=1.
  - Without macro: count wraps to 0, overflow_o=0.
- Reset mid-AD: rst_i asserted for one cycle after 3 blocks -> all outputs 0, state IDLE, blk_ready_o=0.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared AEAD128 constants and types for the size encoder.
package ascon_pack;

    // Width of the in-block byte count (16-byte blocks)
    localparam int PAD_AW    = 4;
    localparam int BLK_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AD   = 2'd1,
        DI   = 2'd2,
        DONE = 2'd3
    } ascon_size_enc_state_e;

endpackage

// File: rtl/ascon_blk_counter.sv
// Full-block counter with synchronous clear.
// Build option ASCON_SIZE_ENC_OVF_EN: saturate at all-ones and raise a sticky
// overflow flag; otherwise the counter wraps and the flag is tied low.
module ascon_blk_counter #(
    parameter int BLOCK_AW = 28
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                inc_i,
    output logic [BLOCK_AW-1:0] cnt_o,
    output logic                ovf_o
);

    logic [BLOCK_AW-1:0] r_cnt;

`ifdef ASCON_SIZE_ENC_OVF_EN
    logic r_ovf;

    // Count blocks, holding at all-ones and flagging any increment beyond it
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (inc_i) begin
            if (&r_cnt) begin
                r_ovf <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign ovf_o = r_ovf;
`else
    // Count blocks modulo 2^BLOCK_AW
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_cnt <= '0;
        end else if (inc_i) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign ovf_o = 1'b0;
`endif

    assign cnt_o = r_cnt;

endmodule

// File: rtl/ascon_size_encoder.sv
// Rebuilds AD and DI byte sizes from the formatted block stream.
// size = {full_block_count, last_block_bytes}; AD phase first, then DI.
// Build option ASCON_SIZE_ENC_OVF_EN: block counters saturate and overflow_o
// reports it; otherwise counters wrap and overflow_o stays 0.
module ascon_size_encoder
    import ascon_pack::*;
#(
    parameter int SIZE_WIDTH = 32,
    parameter int BLOCK_AW   = 28
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  blk_valid_i,
    output logic                  blk_ready_o,
    input  logic                  blk_last_i,
    input  logic [PAD_AW-1:0]     blk_bytes_i,
    output logic [SIZE_WIDTH-1:0] ad_size_o,
    output logic [SIZE_WIDTH-1:0] di_size_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overflow_o
);

    ascon_size_enc_state_e r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [PAD_AW-1:0]     r_ad_pad;
    logic [PAD_AW-1:0]     r_di_pad;

    logic                  w_xfer;
    logic                  w_ad_inc;
    logic                  w_di_inc;
    logic [BLOCK_AW-1:0]   w_ad_cnt;
    logic [BLOCK_AW-1:0]   w_di_cnt;
    logic                  w_ad_ovf;
    logic                  w_di_ovf;

    // start_i wins over any transfer presented in the same cycle
    assign blk_ready_o = ((r_state == AD) || (r_state == DI)) && !start_i;
    assign w_xfer      = blk_valid_i && blk_ready_o;
    assign w_ad_inc    = w_xfer && (r_state == AD) && !blk_last_i;
    assign w_di_inc    = w_xfer && (r_state == DI) && !blk_last_i;

    ascon_blk_counter #(.BLOCK_AW(BLOCK_AW)) u_ad_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (start_i),
        .inc_i (w_ad_inc),
        .cnt_o (w_ad_cnt),
        .ovf_o (w_ad_ovf)
    );

    ascon_blk_counter #(.BLOCK_AW(BLOCK_AW)) u_di_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (start_i),
        .inc_i (w_di_inc),
        .cnt_o (w_di_cnt),
        .ovf_o (w_di_ovf)
    );

    // Phase sequencing; last block of a phase captures its byte count and advances
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ad_pad <= '0;
            r_di_pad <= '0;
        end else if (start_i) begin
            r_state  <= AD;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_ad_pad <= '0;
            r_di_pad <= '0;
        end else if (w_xfer && blk_last_i) begin
            if (r_state == AD) begin
                r_ad_pad <= blk_bytes_i;
                r_state  <= DI;
            end else begin
                r_di_pad <= blk_bytes_i;
                r_state  <= DONE;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
            end
        end
    end

    assign ad_size_o  = {w_ad_cnt, r_ad_pad};
    assign di_size_o  = {w_di_cnt, r_di_pad};
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign overflow_o = w_ad_ovf | w_di_ovf;

endmodule

// File: tb/tb_ascon_size_encoder.sv
// Bench for ascon_size_encoder: a 32-bit instance and a narrow 8-bit instance
// share one stimulus stream and are checked every cycle against a block-count
// model. Honours ASCON_SIZE_ENC_OVF_EN the same way as the design.
module tb_ascon_size_encoder;
    import ascon_pack::*;

    logic       clk = 1'b0;
    logic       rst, start, valid, last;
    logic [3:0] bytes;

    logic        rdy32, busy32, done32, ovf32;
    logic [31:0] ad32, di32;
    logic        rdy8, busy8, done8, ovf8;
    logic [7:0]  ad8, di8;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ascon_size_encoder #(.SIZE_WIDTH(32), .BLOCK_AW(28)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .blk_valid_i(valid),
        .blk_ready_o(rdy32), .blk_last_i(last), .blk_bytes_i(bytes),
        .ad_size_o(ad32), .di_size_o(di32), .busy_o(busy32),
        .done_o(done32), .overflow_o(ovf32)
    );

    ascon_size_encoder #(.SIZE_WIDTH(8), .BLOCK_AW(4)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .blk_valid_i(valid),
        .blk_ready_o(rdy8), .blk_last_i(last), .blk_bytes_i(bytes),
        .ad_size_o(ad8), .di_size_o(di8), .busy_o(busy8),
        .done_o(done8), .overflow_o(ovf8)
    );

    // Model: phase 0 idle, 1 AD, 2 DI, 3 done; block counts kept unbounded
    int     m_phase  = 0;
    longint m_ad_blk = 0, m_di_blk = 0;
    int     m_ad_pad = 0, m_di_pad = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_ad_blk = 0; m_di_blk = 0; m_ad_pad = 0; m_di_pad = 0;
        end else if (start) begin
            m_phase = 1; m_ad_blk = 0; m_di_blk = 0; m_ad_pad = 0; m_di_pad = 0;
        end else if (valid && (m_phase == 1 || m_phase == 2)) begin
            if (last) begin
                if (m_phase == 1) m_ad_pad = int'(bytes); else m_di_pad = int'(bytes);
                m_phase = m_phase + 1;
            end else begin
                if (m_phase == 1) m_ad_blk++; else m_di_blk++;
            end
        end
    end

    function automatic logic [63:0] exp_size(longint blk, int pad, int aw, int sw);
        longint maxc = (longint'(1) << aw) - 1;
        longint c;
`ifdef ASCON_SIZE_ENC_OVF_EN
        c = (blk > maxc) ? maxc : blk;
`else
        c = blk % (maxc + 1);
`endif
        return 64'((c * BLK_BYTES + pad) % (longint'(1) << sw));
    endfunction

    function automatic logic [63:0] exp_ovf(int aw);
`ifdef ASCON_SIZE_ENC_OVF_EN
        longint maxc = (longint'(1) << aw) - 1;
        return 64'((m_ad_blk > maxc) || (m_di_blk > maxc));
`else
        return 64'(aw < 0);
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_rdy;
            exp_rdy = (m_phase == 1 || m_phase == 2) && !start;
            chk("ready32", 64'(rdy32),  64'(exp_rdy));
            chk("busy32",  64'(busy32), 64'(m_phase == 1 || m_phase == 2));
            chk("done32",  64'(done32), 64'(m_phase == 3));
            chk("ad32",    64'(ad32),   exp_size(m_ad_blk, m_ad_pad, 28, 32));
            chk("di32",    64'(di32),   exp_size(m_di_blk, m_di_pad, 28, 32));
            chk("ovf32",   64'(ovf32),  exp_ovf(28));
            chk("ready8",  64'(rdy8),   64'(exp_rdy));
            chk("busy8",   64'(busy8),  64'(m_phase == 1 || m_phase == 2));
            chk("done8",   64'(done8),  64'(m_phase == 3));
            chk("ad8",     64'(ad8),    exp_size(m_ad_blk, m_ad_pad, 4, 8));
            chk("di8",     64'(di8),    exp_size(m_di_blk, m_di_pad, 4, 8));
            chk("ovf8",    64'(ovf8),   exp_ovf(4));
        end
    end

    // Present inputs for one clock, return 1 time unit after the edge
    task automatic drive(input bit s, input bit v, input bit l, input logic [3:0] b, input bit r = 1'b0);
        rst = r; start = s; valid = v; last = l; bytes = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; last = 1'b0; bytes = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        chk("reset_ad",    64'(ad32),   64'd0);
        chk("reset_ready", 64'(rdy32),  64'd0);
        chk("reset_done",  64'(done32), 64'd0);
        rst = 1'b0;

        // Nominal: AD 2 full + 5 bytes = 37, DI 1 full + 0 bytes = 16
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 1, 4'd5);
        drive(0, 1, 0, 0);
        drive(0, 1, 1, 4'd0);
        chk("nom_ad",   64'(ad32),   64'd37);
        chk("nom_di",   64'(di32),   64'd16);
        chk("nom_done", 64'(done32), 64'd1);

        // Valid held in DONE: nothing accepted
        repeat (4) drive(0, 1, 0, 4'd3);
        chk("done_hold_ad", 64'(ad32), 64'd37);
        chk("done_hold_rdy", 64'(rdy32), 64'd0);

        // Both phases empty
        drive(1, 0, 0, 0);
        drive(0, 1, 1, 4'd0);
        drive(0, 1, 1, 4'd0);
        chk("empty_ad",   64'(ad32),   64'd0);
        chk("empty_di",   64'(di32),   64'd0);
        chk("empty_done", 64'(done32), 64'd1);

        // Start with valid in AD: no count
        drive(1, 0, 0, 0);
        drive(1, 1, 0, 0);
        chk("start_prio_ad", 64'(ad32), 64'd0);

        // Restart mid-DI
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 1, 4'd5);
        drive(0, 1, 0, 0);
        chk("mid_di_ad", 64'(ad32), 64'd37);
        drive(1, 0, 0, 0);
        chk("restart_ad",   64'(ad32),   64'd0);
        chk("restart_di",   64'(di32),   64'd0);
        chk("restart_done", 64'(done32), 64'd0);
        chk("restart_busy", 64'(busy32), 64'd1);

        // 16 full AD blocks on the narrow instance
        repeat (16) drive(0, 1, 0, 0);
        chk("ovf_ad32", 64'(ad32), 64'd256);
`ifdef ASCON_SIZE_ENC_OVF_EN
        chk("ovf_ad8",  64'(ad8),  64'd240);
        chk("ovf_flag", 64'(ovf8), 64'd1);
`else
        chk("wrap_ad8",  64'(ad8),  64'd0);
        chk("wrap_flag", 64'(ovf8), 64'd0);
`endif

        // Reset mid-AD
        drive(1, 0, 0, 0);
        repeat (3) drive(0, 1, 0, 0);
        drive(0, 1, 0, 0, 1'b1);
        chk("rst_ad",    64'(ad32),   64'd0);
        chk("rst_busy",  64'(busy32), 64'd0);
        chk("rst_ready", 64'(rdy32),  64'd0);
        drive(0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 75,
                  $urandom_range(0, 99) < 15,
                  4'($urandom_range(0, 15)),
                  $urandom_range(0, 199) == 0);
        end

        // Long AD run to exercise the narrow counter limit under random pads
        drive(1, 0, 0, 0);
        for (int i = 0; i < 40; i++) drive(0, $urandom_range(0, 9) < 9, 0, 0);
        drive(0, 1, 1, 4'($urandom_range(0, 15)));
        for (int i = 0; i < 20; i++) drive(0, 1, 0, 0);
        drive(0, 1, 1, 4'($urandom_range(0, 15)));
        drive(0, 0, 0, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
